// File: rtl/minesweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minesweeper_pkg
// Description : Shared types and constants for the 8x8 Minesweeper board
//               generator and game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package minesweeper_pkg;

  localparam int BOARD_SIZE     = 8;
  localparam int NUM_CELLS      = BOARD_SIZE * BOARD_SIZE;
  localparam int BOMB_COUNT_MIN = 1;
  localparam int BOMB_COUNT_MAX = 63;

  typedef logic [3:0] cell_t;

  localparam cell_t BOMB_VALUE = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PLACE = 3'd2,
    COUNT = 3'd3,
    DONE  = 3'd4
  } gen_state_t;

  // Switch value 0 still yields a playable board; the cap keeps one safe cell.
  function automatic logic [5:0] clamp_target(input logic [7:0] bc);
    logic [5:0] t;
    if (bc == 8'd0)
      t = 6'(BOMB_COUNT_MIN);
    else if (bc > 8'(BOMB_COUNT_MAX))
      t = 6'(BOMB_COUNT_MAX);
    else
      t = bc[5:0];
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/minesweeper_board_gen_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr_q <= SEED;
    else
      lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/minesweeper_board_gen.sv
`default_nettype none
// ============================================================================
// Module      : minesweeper_board_gen
// Description : Clears the 8x8 board, scatters bombs from an LFSR, then fills
//               neighbour counts; the board is read through a registered port.
// Revision    : 1.0 - initial release
// ============================================================================
module minesweeper_board_gen
  import minesweeper_pkg::*;
#(
  parameter int          BOARD_SIZE = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bomb_count,
  output logic       busy,
  output logic       done,
  output logic       board_valid,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [3:0] rd_data
);

  localparam logic [5:0] LAST_IDX = 6'(BOARD_SIZE * BOARD_SIZE - 1);

  logic [15:0] lfsr_w;
  logic        unused_lfsr;
  logic [5:0]  cand_idx;

  gen_state_t  state_q;
  cell_t       cell_q [64];
  logic [5:0]  target_q;
  logic [5:0]  placed_q;
  logic [5:0]  scan_q;
  logic        busy_q;
  logic        done_q;
  logic        valid_q;
  cell_t       rd_data_q;

  logic [63:0] bomb_map;
  logic [2:0]  scan_row;
  logic [2:0]  scan_col;
  logic        has_up;
  logic        has_dn;
  logic        has_lf;
  logic        has_rt;
  logic [7:0]  nb;
  cell_t       count_d;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr_w)
  );

  assign cand_idx    = lfsr_w[5:0];
  assign unused_lfsr = ^lfsr_w[15:6];

  for (genvar k = 0; k < 64; k++) begin : g_bomb_map
    assign bomb_map[k] = (cell_q[k] == BOMB_VALUE);
  end

  // Edge flags mask neighbours so the 6-bit index arithmetic never wraps rows.
  assign scan_row = scan_q[5:3];
  assign scan_col = scan_q[2:0];
  assign has_up   = (scan_row != 3'd0);
  assign has_dn   = (scan_row != 3'd7);
  assign has_lf   = (scan_col != 3'd0);
  assign has_rt   = (scan_col != 3'd7);

  assign nb[0] = has_up & has_lf & bomb_map[scan_q - 6'd9];
  assign nb[1] = has_up          & bomb_map[scan_q - 6'd8];
  assign nb[2] = has_up & has_rt & bomb_map[scan_q - 6'd7];
  assign nb[3] = has_lf          & bomb_map[scan_q - 6'd1];
  assign nb[4] = has_rt          & bomb_map[scan_q + 6'd1];
  assign nb[5] = has_dn & has_lf & bomb_map[scan_q + 6'd7];
  assign nb[6] = has_dn          & bomb_map[scan_q + 6'd8];
  assign nb[7] = has_dn & has_rt & bomb_map[scan_q + 6'd9];

  always_comb begin
    count_d = 4'd0;
    for (int k = 0; k < 8; k++)
      count_d = count_d + {3'b000, nb[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= 6'd1;
      placed_q  <= 6'd0;
      scan_q    <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      rd_data_q <= 4'd0;
      for (int k = 0; k < 64; k++)
        cell_q[k] <= 4'd0;
    end else begin
      rd_data_q <= cell_q[{rd_row, rd_col}];
      case (state_q)
        IDLE: begin
          if (start) begin
            target_q <= clamp_target(bomb_count);
            valid_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          for (int k = 0; k < 64; k++)
            cell_q[k] <= 4'd0;
          placed_q <= 6'd0;
          state_q  <= PLACE;
        end
        PLACE: begin
          // A candidate that already holds a bomb just burns the cycle.
          if (!bomb_map[cand_idx]) begin
            cell_q[cand_idx] <= BOMB_VALUE;
            placed_q         <= placed_q + 6'd1;
            if (placed_q + 6'd1 == target_q) begin
              scan_q  <= 6'd0;
              state_q <= COUNT;
            end
          end
        end
        COUNT: begin
          if (!bomb_map[scan_q])
            cell_q[scan_q] <= count_d;
          scan_q <= scan_q + 6'd1;
          if (scan_q == LAST_IDX) begin
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign board_valid = valid_q;
  assign rd_data     = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_minesweeper_board_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_minesweeper_board_gen
// Description : Directed self-checking bench for minesweeper_board_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_minesweeper_board_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bomb_count;
  logic       busy;
  logic       done;
  logic       board_valid;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [3:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [3:0]  exp_q [$];
  logic [3:0]  cap   [64];
  logic [63:0] sig1;
  logic [63:0] sig2;

  minesweeper_board_gen #(
    .BOARD_SIZE (8),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bomb_count  (bomb_count),
    .busy        (busy),
    .done        (done),
    .board_valid (board_valid),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic rd_cap(input int idx, output logic [3:0] v);
    @(negedge clk);
    rd_row = 3'(idx >> 3);
    rd_col = 3'(idx & 7);
    @(negedge clk);
    v = rd_data;
  endtask

  // Expected value must already be queued; the registered output pops it.
  task automatic rd_chk(input int idx, input string tag);
    logic [3:0] v;
    rd_cap(idx, v);
    chk(tag, 32'(v), 32'(exp_q.pop_front()));
  endtask

  function automatic int nb_count(input int idx);
    int r = idx / 8;
    int c = idx % 8;
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) <= 7 &&
            (c + dc) >= 0 && (c + dc) <= 7)
          if (cap[(r + dr) * 8 + (c + dc)] == 4'hF)
            n++;
    return n;
  endfunction

  task automatic verify_board(input int exp_bombs, input string tag, output logic [63:0] sig);
    int nbomb = 0;
    for (int i = 0; i < 64; i++) begin
      rd_cap(i, cap[i]);
      sig[i] = (cap[i] == 4'hF);
      if (cap[i] == 4'hF) nbomb++;
    end
    chk({tag, " bomb total"}, 32'(nbomb), 32'(exp_bombs));
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back((cap[i] == 4'hF) ? 4'hF : 4'(nb_count(i)));
      rd_chk(i, {tag, " cell"});
    end
  endtask

  task automatic check_zero_board(input string tag);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(4'd0);
      rd_chk(i, tag);
    end
  endtask

  task automatic run_gen(input logic [7:0] bc, input int tgt, input bit retrig, input string tag);
    int cycles = 1;
    int ndone  = 0;
    int lat    = 0;
    bit bv_bad = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    bomb_count = bc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    chk({tag, " valid cleared"}, 32'(board_valid), 32'd0);
    while (ndone == 0 && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      if (retrig && cycles == 22) begin
        start      = 1'b1;
        bomb_count = 8'd40;
      end else if (retrig && cycles == 23) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        lat = cycles + 1;
      end else if (board_valid) begin
        bv_bad = 1'b1;
      end
    end
    chk({tag, " done seen"}, 32'(ndone), 32'd1);
    chk({tag, " valid low while busy"}, 32'(bv_bad), 32'd0);
    chk({tag, " latency min"}, 32'(lat >= tgt + 66), 32'd1);
    chk({tag, " valid with done"}, 32'(board_valid), 32'd1);
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk({tag, " single done"}, 32'(ndone), 32'd1);
    chk({tag, " busy idle"}, 32'(busy), 32'd0);
    chk({tag, " valid held"}, 32'(board_valid), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    bomb_count = 8'd0;
    rd_row     = 3'd0;
    rd_col     = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset valid", 32'(board_valid), 32'd0);
    check_zero_board("reset cell");

    run_gen(8'd10, 10, 1'b0, "g10");
    verify_board(10, "g10", sig1);

    run_gen(8'd0, 1, 1'b0, "g0");
    verify_board(1, "g0", sig1);

    // Restart attempt mid-PLACE with a different count must be ignored.
    run_gen(8'd200, 63, 1'b1, "g200");
    verify_board(63, "g200", sig1);
    for (int s = 0; s < 64; s++) begin
      if (cap[s] != 4'hF) begin
        int  r = s / 8;
        int  c = s % 8;
        bit  er = (r == 0 || r == 7);
        bit  ec = (c == 0 || c == 7);
        chk("g200 safe cell", 32'(cap[s]), (er && ec) ? 32'd3 : ((er || ec) ? 32'd5 : 32'd8));
      end
    end

    #2 rst = 1'b1;
    #1 chk("rst drops valid", 32'(board_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in PLACE.
    @(negedge clk);
    start      = 1'b1;
    bomb_count = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("place busy before rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("place rst busy", 32'(busy), 32'd0);
    chk("place rst valid", 32'(board_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_zero_board("place rst cell");

    // Reset in COUNT.
    @(negedge clk);
    start      = 1'b1;
    bomb_count = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("count busy before rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("count rst busy", 32'(busy), 32'd0);
    chk("count rst valid", 32'(board_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_zero_board("count rst cell");

    run_gen(8'd5, 5, 1'b0, "g5");
    verify_board(5, "g5", sig1);

    run_gen(8'd20, 20, 1'b0, "b2b first");
    verify_board(20, "b2b first", sig1);
    repeat (3) @(negedge clk);
    run_gen(8'd20, 20, 1'b0, "b2b second");
    verify_board(20, "b2b second", sig2);
    chk("b2b layouts differ", 32'(sig1 != sig2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/minesweeper_board_gen.md
Name: minesweeper_board_gen

Overview:
Upstream board generator for the 8x8 Minesweeper game FSM. On a start request it clears the board and places the requested number of distinct bombs at pseudo-random cells using a free-running LFSR. It then fills every non-bomb cell with its adjacent-bomb count and signals completion. The game FSM reads the finished board through a registered read port; it must not leave CONFIGURE before board_valid is high.

Parameters:
BOARD_SIZE, 8, board rows and columns (fixed at 8; index widths are 3 bits).
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
start  input  1  one-cycle request to generate a new board. Ignored while busy.
bomb_count  input  8  requested bombs, taken from the switches. Clamped to the range 1..63.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when the board is complete.
board_valid  output  1  high after done; cleared when start is accepted or on reset.
rd_row  input  3  read row index.
rd_col  input  3  read column index.
rd_data  output  4  cell at (rd_row, rd_col), registered. Values 0..8 are neighbour counts; 4'hF is a bomb.

Behaviour:
- Reset values: every cell 0; rd_data 0; busy 0; done 0; board_valid 0; state IDLE; LFSR set to LFSR_SEED.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle, including in IDLE, so the board depends on when start is pressed.
  - Candidate cell index = lfsr[5:0]; row = index[5:3], column = index[2:0].
- Target: target = 1 if bomb_count is 0; 63 if bomb_count is above 63; otherwise bomb_count[5:0]. Latched when start is accepted; later bomb_count changes have no effect.
- State IDLE: when start is high, latch target, clear board_valid, go to CLEAR.
- State CLEAR: one cycle. Write all 64 cells to 0, set placed = 0, go to PLACE. busy = 1.
- State PLACE:
  - Each cycle, if the candidate cell is not 4'hF, write 4'hF and increment placed.
  - If the candidate is already a bomb, skip it; this consumes the cycle with no write.
  - Go to COUNT in the cycle after placed reaches target.
  - Duration is at least target cycles; there is no upper bound other than LFSR period coverage.
- State COUNT:
  - Scan cells in index order 0..63, one per cycle.
  - A bomb cell is left unchanged.
  - Any other cell gets the number of its 8-connected neighbours equal to 4'hF (0..8).
  - Neighbours outside the board are not counted: no wrap-around at row or column 0 or 7.
  - After index 63, go to DONE.
- State DONE: one cycle. done = 1, board_valid set, busy = 0 from the next cycle, return to IDLE.
- Latency from start to done: 1 (CLEAR) + PLACE cycles + 64 + 1. Minimum is 67 cycles for target = 1.
- start while busy is ignored, with no queueing. start held high in IDLE after DONE starts a new generation.
- Read port:
  - rd_data <= cell[rd_row][rd_col] every cycle, in every state; one-cycle latency.
  - The value is meaningful only while board_valid is high.
- Reset during any state aborts immediately and restores all reset values. No partial board remains.

Decomposition:
- Package minesweeper_pkg:
  - BOARD_SIZE = 8, BOMB_VALUE = 4'hF, BOMB_COUNT_MIN = 1, BOMB_COUNT_MAX = 63.
  - cell_t: 4-bit logic typedef.
  - gen_state_t: enum {IDLE, CLEAR, PLACE, COUNT, DONE}.
  - Shared with the game FSM.
- One sub-module, lfsr16: clk, rst, seed parameter, 16-bit state output, advancing every cycle.
- Neighbour counting stays in this block as combinational logic around the scan index.

Test Plan:
- Reset, then idle 5 cycles -> busy 0, done 0, board_valid 0; all 64 reads return 0 with one-cycle latency.
- start with bomb_count = 10 -> busy the next cycle, done exactly once at least 76 cycles later, board_valid 1.
  - Exactly 10 cells read 4'hF.
  - Every other cell matches the reference-model neighbour count.
  - Corner cells are at most 3; edge cells at most 5.
- start with bomb_count = 0 -> exactly 1 bomb. start with bomb_count = 200 -> exactly 63 bombs.
  - The single safe cell reads 3 if it is a corner, 5 if an edge, 8 if interior.
- Pulse start again 20 cycles into PLACE, and change bomb_count to 40 -> no restart; final bomb count equals the original target; a single done pulse.
- Assert rst during PLACE and again during COUNT -> busy and board_valid drop immediately; all cells read 0.
  - A following start with bomb_count = 5 produces a valid 5-bomb board.
- Two back-to-back generations with bomb_count = 20 -> board_valid low from accept until the second done.
  - 20 bombs each time; layouts differ when the starts occur at different LFSR phases.
